tilemap_layer: RTL and testbench
================================

// Module: tilemap_layer
// PURPOSE
//  Parametrised scrolling tilemap layer: CPU-writable map RAM, optional per-line
//  row-scroll table, tile fetch from an external graphics ROM port, and per-pixel
//  colour/opacity output for the video mixer. Adds configurable map size, tile
//  flip X/Y, row-scroll mode, layer enable and transparency over the fixed layer.
// PARAMETERS
//  MAP_W_LOG2   7   log2 map width in 8x8 tiles (wraps)
//  MAP_H_LOG2   7   log2 map height in tiles (wraps)
//  CODE_W       10  tile code width; gfx_addr = {code, row}, width CODE_W+3
//  LINES_LOG2   9   log2 entries in the row-scroll table
// PORTS
//  clk          in   1    system clock
//  reset        in   1    asynchronous, active-high reset
//  ce_pixel     in   1    pixel enable; pulses are at least 2 clk apart
//  wr           in   2    byte write strobes {hi,lo}
//  cs_ram       in   1    map RAM select; word index = address[MAP_W_LOG2+MAP_H_LOG2-1:0]
//  cs_rs        in   1    row-scroll RAM select; index = address[LINES_LOG2-1:0]
//  cs_reg       in   1    register select; address[1:0]: 0 hofs, 1 vofs, 2 ctrl
//  address      in   16   CPU word address
//  din          in   16   CPU write data
//  dout         out  16   CPU read data (selected RAM/register)
//  hcnt, vcnt   in   12   raster counters
//  gfx_addr     out  CODE_W+3  graphics ROM row address (registered)
//  gfx_data     in   32   8 pixels x 4bpp; pixel 0 in [31:28]
//  color_out    out  8    {palette,pixel}; 0 when transparent/disabled
//  opaque       out  1    pixel index != 0 and layer enabled
// BEHAVIOUR
//  - Reset: hofs=vofs=0, ctrl=0 (layer disabled, row-scroll off), color_out=0,
//    opaque=0, gfx_addr=0, shifter cleared. RAM contents are not reset.
//  - ctrl[0] enable, ctrl[1] row-scroll enable, ctrl[15:2] read back as 0.
//  - Byte writes honour wr[1:0] independently for all regs/RAMs. dout = reg value
//    when cs_reg, else RAM port-A q (1 clk read latency).
//  - V = vcnt + vofs; Hs = ctrl[1] ? rowscroll[vcnt[LINES_LOG2-1:0]] : hofs;
//    H = hcnt + Hs. All sums 12-bit wrap; tile column/row = H[..:3], V[..:3]
//    modulo 2^MAP_W_LOG2 / 2^MAP_H_LOG2.
//  - Map entry: [15:12] palette, [11] flipY, [10] flipX, [CODE_W-1:0] code.
//  - Fetch pipeline keyed on H[2:0], advancing only on ce_pixel:
//    * map port-B address = {V row, (H col + 1) wrapped} (next tile, continuous)
//    * phase 0: latch entry -> pending
//    * phase 1: gfx_addr <= {pending.code, V[2:0] ^ {3{pending.flipY}}}
//    * phase 7: shifter <= flipX ? nibble-reversed gfx_data : gfx_data;
//      pal <= pending.palette. ROM latency must be <= 5 pixel periods.
//    * other phases: shifter shifts left 4.
//  - Output: each ce, pix = shifter[31:28]; color_out <= en&&pix!=0 ? {pal,pix}:0;
//    opaque <= en && pix!=0. Latency: pixel at H appears one ce after H is presented.
//  - Row-scroll value sampled per pixel from vcnt; a mid-line change to the table
//    takes effect at the next tile boundary reached by H.
//  - hofs/vofs writes mid-line take effect on the next ce (may tear; acceptable).
//  - Disabled layer still fetches (pipeline stays warm); only outputs forced 0.
//  - Reset asserted mid-line: all pipeline state cleared immediately; first valid
//    pixels after release follow the first complete phase 0..7 fetch.
// STRUCTURE
//  - tilemap_pkg: map-entry struct, register index constants, ctrl bit indices.
//  - Map and row-scroll storage: existing dualport_ram, split into byte lanes.
//  - Sub-module tilemap_pixel_shifter: load/flip/shift and output register.
// TESTING
//  - Reset, then read regs -> hofs=vofs=ctrl=0, color_out=0, opaque=0.
//  - Entry 0x3005 at tile (0,0), gfx row 0 = 0x12345678, en=1, scroll 0 ->
//    color_out for pixels 0..7 = 0x31,0x32..0x38; opaque=1 throughout.
//  - Same with flipX (0x3405) -> 0x38..0x31; flipY -> gfx_addr row = 7 on line 0.
//  - hofs=0x3FC with MAP_W_LOG2=7 -> tile col wraps 127->0; pixel sequence continuous.
//  - Row-scroll on, table[10]=4, else 0 -> only line 10 shifted 4 pixels left.
//  - Pixel value 0 -> color_out=0, opaque=0; ctrl=0 -> all outputs 0; byte write
//    wr=2'b10 to hofs changes only [15:8].

Source files
------------

// File: rtl/tilemap_pkg.sv
// Shared types and constants for the scrolling tilemap layer.
package tilemap_pkg;

  localparam logic [1:0] REG_HOFS = 2'd0;
  localparam logic [1:0] REG_VOFS = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;

  localparam int CTRL_EN = 0;
  localparam int CTRL_RS = 1;

  // Map RAM word layout; code is the widest supported tile code field.
  typedef struct packed {
    logic [3:0] palette;
    logic       flip_y;
    logic       flip_x;
    logic [9:0] code;
  } map_entry_t;

  function automatic logic [31:0] nibble_reverse(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[i*4 +: 4] = d[(7-i)*4 +: 4];
    return r;
  endfunction

endpackage

// File: rtl/tilemap_pixel_shifter.sv
// Tile row shifter: loads (optionally mirrored) 8 pixels, shifts one per pixel
// enable and registers the colour/opacity seen by the mixer.
module tilemap_pixel_shifter
  import tilemap_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        load,
  input  logic        flip_x,
  input  logic [31:0] load_data,
  input  logic [3:0]  load_pal,
  input  logic        en,
  output logic [7:0]  color_out,
  output logic        opaque
);

  logic [31:0] shifter_reg;
  logic [3:0]  pal_reg;
  logic [3:0]  pix;

  assign pix = shifter_reg[31:28];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shifter_reg <= '0;
      pal_reg     <= '0;
      color_out   <= '0;
      opaque      <= 1'b0;
    end else if (ce) begin
      if (load) begin
        shifter_reg <= flip_x ? nibble_reverse(load_data) : load_data;
        pal_reg     <= load_pal;
      end else begin
        shifter_reg <= {shifter_reg[27:0], 4'h0};
      end
      // The pixel leaving the shifter now is the one for the H just presented.
      color_out <= (en && pix != 4'h0) ? {pal_reg, pix} : 8'h00;
      opaque    <= en && pix != 4'h0;
    end
  end

endmodule

// File: rtl/tilemap_layer.sv
// Scrolling tilemap layer: CPU map/row-scroll RAMs, scroll registers, next-tile
// fetch into the graphics ROM and the per-pixel output stage.
module tilemap_layer
  import tilemap_pkg::*;
#(
  parameter int MAP_W_LOG2 = 7,
  parameter int MAP_H_LOG2 = 7,
  parameter int CODE_W     = 10,
  parameter int LINES_LOG2 = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_pixel,
  input  logic [1:0]        wr,
  input  logic              cs_ram,
  input  logic              cs_rs,
  input  logic              cs_reg,
  input  logic [15:0]       address,
  input  logic [15:0]       din,
  output logic [15:0]       dout,
  input  logic [11:0]       hcnt,
  input  logic [11:0]       vcnt,
  output logic [CODE_W+2:0] gfx_addr,
  input  logic [31:0]       gfx_data,
  output logic [7:0]        color_out,
  output logic              opaque
);

  localparam int MAP_AW    = MAP_W_LOG2 + MAP_H_LOG2;
  localparam int MAP_WORDS = 1 << MAP_AW;
  localparam int RS_WORDS  = 1 << LINES_LOG2;

  logic [15:0] hofs_reg, vofs_reg;
  logic [1:0]  ctrl_reg;
  logic        rs_sel_reg;
  logic [15:0] map_qa, map_qb, rs_qa, rs_qb;
  logic [15:0] reg_val;
  logic [11:0] hs, h, v;
  logic [MAP_W_LOG2-1:0] next_col;
  logic [MAP_AW-1:0]     map_addr_a, map_addr_b;
  logic [LINES_LOG2-1:0] rs_addr_a, rs_addr_b;
  map_entry_t  pending;

  assign map_addr_a = address[MAP_AW-1:0];
  assign rs_addr_a  = address[LINES_LOG2-1:0];
  assign rs_addr_b  = vcnt[LINES_LOG2-1:0];

  // Each byte lane is its own RAM so byte strobes map onto plain write enables.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [7:0] map_mem [MAP_WORDS];
    logic [7:0] rs_mem  [RS_WORDS];
    logic [7:0] map_qa_lane, map_qb_lane, rs_qa_lane, rs_qb_lane;

    always_ff @(posedge clk) begin
      if (cs_ram && wr[gi]) map_mem[map_addr_a] <= din[gi*8 +: 8];
      if (cs_rs && wr[gi])  rs_mem[rs_addr_a]   <= din[gi*8 +: 8];
      map_qa_lane <= map_mem[map_addr_a];
      map_qb_lane <= map_mem[map_addr_b];
      rs_qa_lane  <= rs_mem[rs_addr_a];
      rs_qb_lane  <= rs_mem[rs_addr_b];
    end

    assign map_qa[gi*8 +: 8] = map_qa_lane;
    assign map_qb[gi*8 +: 8] = map_qb_lane;
    assign rs_qa[gi*8 +: 8]  = rs_qa_lane;
    assign rs_qb[gi*8 +: 8]  = rs_qb_lane;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hofs_reg   <= '0;
      vofs_reg   <= '0;
      ctrl_reg   <= '0;
      rs_sel_reg <= 1'b0;
    end else begin
      rs_sel_reg <= cs_rs;
      if (cs_reg && address[1:0] == REG_HOFS) begin
        if (wr[0]) hofs_reg[7:0]  <= din[7:0];
        if (wr[1]) hofs_reg[15:8] <= din[15:8];
      end
      if (cs_reg && address[1:0] == REG_VOFS) begin
        if (wr[0]) vofs_reg[7:0]  <= din[7:0];
        if (wr[1]) vofs_reg[15:8] <= din[15:8];
      end
      if (cs_reg && address[1:0] == REG_CTRL && wr[0]) ctrl_reg <= din[1:0];
    end
  end

  always_comb begin
    reg_val = 16'h0000;
    case (address[1:0])
      REG_HOFS: reg_val = hofs_reg;
      REG_VOFS: reg_val = vofs_reg;
      REG_CTRL: reg_val = {14'h0000, ctrl_reg};
      default:  reg_val = 16'h0000;
    endcase
    dout = cs_reg ? reg_val : (rs_sel_reg ? rs_qa : map_qa);
  end

  assign hs         = ctrl_reg[CTRL_RS] ? rs_qb[11:0] : hofs_reg[11:0];
  assign h          = hcnt + hs;
  assign v          = vcnt + vofs_reg[11:0];
  assign next_col   = h[MAP_W_LOG2+2:3] + (MAP_W_LOG2)'(1);
  assign map_addr_b = {v[MAP_H_LOG2+2:3], next_col};

  // The entry for the next tile is captured while the current tile is shown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      gfx_addr <= '0;
    end else if (ce_pixel) begin
      if (h[2:0] == 3'd0) pending <= map_entry_t'(map_qb);
      if (h[2:0] == 3'd1) gfx_addr <= {pending.code[CODE_W-1:0], v[2:0] ^ {3{pending.flip_y}}};
    end
  end

  tilemap_pixel_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce_pixel),
    .load      (h[2:0] == 3'd7),
    .flip_x    (pending.flip_x),
    .load_data (gfx_data),
    .load_pal  (pending.palette),
    .en        (ctrl_reg[CTRL_EN]),
    .color_out (color_out),
    .opaque    (opaque)
  );

  logic unused_bits;
  assign unused_bits = ^{address, h, v, rs_qb, hofs_reg, vofs_reg, pending};

endmodule

// File: tb/tb_tilemap_layer.sv
// Directed bench for tilemap_layer: registers, RAM access and pixel output cases.
module tb_tilemap_layer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce_pixel = 1'b0;
  logic [1:0]  wr = 2'b00;
  logic        cs_ram = 1'b0, cs_rs = 1'b0, cs_reg = 1'b0;
  logic [15:0] address = '0, din = '0;
  logic [15:0] dout;
  logic [11:0] hcnt = '0, vcnt = '0;
  logic [12:0] gfx_addr;
  logic [31:0] gfx_data = '0;
  logic [7:0]  color_out;
  logic        opaque;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] rom [8192];
  logic [7:0]  cap_col [32];
  logic        cap_opq [32];
  logic [12:0] cap_ga  [32];
  logic [15:0] rd;

  tilemap_layer dut (
    .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .wr(wr),
    .cs_ram(cs_ram), .cs_rs(cs_rs), .cs_reg(cs_reg),
    .address(address), .din(din), .dout(dout),
    .hcnt(hcnt), .vcnt(vcnt),
    .gfx_addr(gfx_addr), .gfx_data(gfx_data),
    .color_out(color_out), .opaque(opaque)
  );

  always #5 clk = ~clk;

  // Graphics ROM model with one clock of latency.
  always @(posedge clk) gfx_data <= rom[gfx_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else begin
      n_pass++;
      $display("check %s ok (%h)", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] idx, input logic [15:0] data, input logic [1:0] be);
    cs_reg = 1'b1; address = {14'h0, idx}; din = data; wr = be;
    tick();
    cs_reg = 1'b0; wr = 2'b00;
  endtask

  task automatic reg_read(input logic [1:0] idx, output logic [15:0] data);
    cs_reg = 1'b1; address = {14'h0, idx}; wr = 2'b00;
    #1 data = dout;
    cs_reg = 1'b0;
  endtask

  task automatic ram_write(input logic sel_rs, input logic [15:0] addr, input logic [15:0] data);
    cs_ram = !sel_rs; cs_rs = sel_rs; address = addr; din = data; wr = 2'b11;
    tick();
    cs_ram = 1'b0; cs_rs = 1'b0; wr = 2'b00;
  endtask

  task automatic ram_read(input logic sel_rs, input logic [15:0] addr, output logic [15:0] data);
    cs_ram = !sel_rs; cs_rs = sel_rs; address = addr; wr = 2'b00;
    tick();
    data = dout;
    cs_ram = 1'b0; cs_rs = 1'b0;
  endtask

  // Map word address of tile (row, col) with a 128-wide map.
  function automatic logic [15:0] tile(input int row, input int col);
    return 16'(row * 128 + col);
  endfunction

  // Present n consecutive hcnt values (one ce each) and capture the outputs.
  task automatic run_line(input int line, input int hstart, input int n);
    vcnt = 12'(line);
    hcnt = 12'(hstart);
    tick(); tick(); tick();
    for (int i = 0; i < n; i++) begin
      hcnt = 12'(hstart + i);
      tick();
      ce_pixel = 1'b1;
      tick();
      ce_pixel = 1'b0;
      cap_col[i] = color_out;
      cap_opq[i] = opaque;
      cap_ga[i]  = gfx_addr;
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) rom[i] = 32'h0;
    for (int r = 0; r < 7; r++) rom[40 + r] = 32'h12345678;
    rom[47] = 32'h87654321;

    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_color", color_out, 8'h00);
    check("rst_opaque", opaque, 1'b0);
    check("rst_gfx_addr", gfx_addr, 13'h0);
    reg_read(2'd0, rd); check("rst_hofs", rd, 16'h0000);
    reg_read(2'd1, rd); check("rst_vofs", rd, 16'h0000);
    reg_read(2'd2, rd); check("rst_ctrl", rd, 16'h0000);

    reg_write(2'd0, 16'h1234, 2'b11);
    reg_write(2'd0, 16'hABCD, 2'b10);
    reg_read(2'd0, rd); check("hofs_hi_byte", rd, 16'hAB34);
    reg_write(2'd1, 16'h5566, 2'b01);
    reg_read(2'd1, rd); check("vofs_lo_byte", rd, 16'h0066);
    reg_write(2'd2, 16'hFFFF, 2'b11);
    reg_read(2'd2, rd); check("ctrl_mask", rd, 16'h0003);
    reg_write(2'd0, 16'h0000, 2'b11);
    reg_write(2'd1, 16'h0000, 2'b11);
    reg_write(2'd2, 16'h0001, 2'b11);

    for (int r = 0; r < 2; r++) begin
      ram_write(1'b0, tile(r, 126), 16'h0000);
      ram_write(1'b0, tile(r, 127), 16'h0000);
      ram_write(1'b0, tile(r, 0),   16'h3005);
      ram_write(1'b0, tile(r, 1),   16'h7000);
    end
    ram_write(1'b1, 16'd8,  16'h0000);
    ram_write(1'b1, 16'd10, 16'h0004);
    ram_read(1'b0, tile(0, 0), rd); check("map_readback", rd, 16'h3005);
    ram_read(1'b1, 16'd10, rd);     check("rs_readback", rd, 16'h0004);

    // Plain tile at (0,0): pixels 0..7 at hcnt 0..7 (capture index 8..15).
    run_line(0, 4088, 17);
    check("plain_gfx_addr", cap_ga[1], 13'd40);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("plain_pix%0d", k), cap_col[8 + k], 32'h31 + k);
      check($sformatf("plain_opq%0d", k), cap_opq[8 + k], 1'b1);
    end
    check("zero_pix_color", cap_col[16], 8'h00);
    check("zero_pix_opaque", cap_opq[16], 1'b0);

    ram_write(1'b0, tile(0, 0), 16'h3405);
    run_line(0, 4088, 17);
    check("flipx_first", cap_col[8], 8'h38);
    check("flipx_mid", cap_col[11], 8'h35);
    check("flipx_last", cap_col[15], 8'h31);

    ram_write(1'b0, tile(0, 0), 16'h3805);
    run_line(0, 4088, 17);
    check("flipy_gfx_addr", cap_ga[1], 13'd47);
    check("flipy_first", cap_col[8], 8'h38);
    check("flipy_last", cap_col[15], 8'h31);
    ram_write(1'b0, tile(0, 0), 16'h3005);

    reg_write(2'd2, 16'h0000, 2'b11);
    run_line(0, 4088, 17);
    check("disabled_color", cap_col[8], 8'h00);
    check("disabled_opaque", cap_opq[8], 1'b0);
    reg_write(2'd2, 16'h0001, 2'b11);

    // hofs 0x3FC: tile 127 then wrap to tile 0 with no gap.
    ram_write(1'b0, tile(0, 127), 16'h2005);
    reg_write(2'd0, 16'h03FC, 2'b11);
    run_line(0, 4084, 24);
    check("wrap_col127_first", cap_col[8], 8'h21);
    check("wrap_col127_last", cap_col[15], 8'h28);
    check("wrap_col0_first", cap_col[16], 8'h31);
    check("wrap_col0_last", cap_col[23], 8'h38);
    reg_write(2'd0, 16'h0000, 2'b11);
    ram_write(1'b0, tile(0, 127), 16'h0000);

    // Row scroll: line 10 shifted by 4, line 8 unshifted.
    reg_write(2'd2, 16'h0003, 2'b11);
    run_line(10, 4080, 24);
    check("rs10_at_4092", cap_col[12], 8'h31);
    check("rs10_at_0", cap_col[16], 8'h35);
    check("rs10_at_3", cap_col[19], 8'h38);
    run_line(8, 4080, 24);
    check("rs8_at_4092", cap_col[12], 8'h00);
    check("rs8_at_0", cap_col[16], 8'h31);
    check("rs8_at_7", cap_col[23], 8'h38);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
